// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter, paced by the transmitter busy flag.
// Optional statistics counters are enabled with `define UART_TX_FIFO_STATS_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_en,
  input  logic                  tx_busy,
  output logic [1:0]            fsm_state
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]           sent_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state, state_nx;
  logic [TW-1:0]           timer, timer_nx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count_nx;
  logic                    wr_ok;
  logic                    pop;

  // Handshakes: a write is taken when wr_en=1 and the registered full=0, otherwise
  // it is dropped and flagged by overflow. A byte is offered downstream only when
  // tx_busy=0 in IDLE; tx_data_en is a single-cycle strobe with tx_data stable.
  assign wr_ok     = wr_en && !full;
  assign pop       = (state == IDLE) && !empty && !tx_busy;
  assign fsm_state = state;

  always_comb begin
    count_nx = count;
    case ({wr_ok, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    case (state)
      IDLE: begin
        if (pop) state_nx = LAUNCH;
      end
      LAUNCH: begin
        state_nx = WAIT_BUSY;
        timer_nx = '0;
      end
      WAIT_BUSY: begin
        // A transmitter that never acknowledges must not stall the queue.
        if (tx_busy)                             state_nx = WAIT_DONE;
        else if (timer == TW'(BUSY_TIMEOUT - 1)) state_nx = IDLE;
        else                                     timer_nx = timer + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
      tx_data    <= '0;
      tx_data_en <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      count    <= count_nx;
      full     <= (count_nx == (DEPTH_LOG2 + 1)'(DEPTH));
      empty    <= (count_nx == '0);
      overflow <= wr_en && full;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      // Strobe is the registered image of LAUNCH, so data has settled a cycle earlier.
      tx_data_en <= (state == LAUNCH);
    end
  end

`ifdef UART_TX_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      if (state == LAUNCH) sent_count <= sent_count + 1'b1;
      if (wr_en && full && (drop_count != 16'hFFFF)) drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule
